writeback_stage: RTL and testbench

MEM/WB pipeline register plus write-back logic for the pipelined RV32I core; the writer side of the register file. It captures the retiring instruction from the memory stage and extracts and sign/zero-extends load data. It selects the write-back source and drives DataD/AddrD/RegWEn into the register file, which commits on the following negedge. It also counts retired instructions and flags misaligned loads.

---
 rtl/riscv_pkg.sv | 30 +++
 rtl/writeback_stage_if.sv | 31 +++
 rtl/load_extend.sv | 53 +++++
 rtl/writeback_stage.sv | 88 ++++++++
 tb/tb_writeback_stage.sv | 217 +++++++++++++++++++++
 5 files changed

// File: rtl/riscv_pkg.sv
// Shared RV32I core definitions: write-back source selects, load funct3 encodings
// and the MEM/WB pipeline payload.
package riscv_pkg;

    localparam int unsigned XLEN   = 32;
    localparam int unsigned REG_AW = 5;

    localparam logic [1:0] WB_SEL_ALU  = 2'b00;
    localparam logic [1:0] WB_SEL_MEM  = 2'b01;
    localparam logic [1:0] WB_SEL_PC4  = 2'b10;
    localparam logic [1:0] WB_SEL_RSVD = 2'b11;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    typedef struct packed {
        logic              valid;
        logic [REG_AW-1:0] rd;
        logic              reg_wen;
        logic [1:0]        wb_sel;
        logic [XLEN-1:0]   alu_result;
        logic [XLEN-1:0]   pc_plus4;
        logic [XLEN-1:0]   mem_rdata;
        logic [2:0]        funct3;
    } memwb_t;

endpackage

// File: rtl/writeback_stage_if.sv
// Memory-stage to write-back bus plus the register-file write port it produces.
interface writeback_stage_if #(
    parameter int unsigned DATA_WIDTH = 32
);
    logic                  in_valid;
    logic [4:0]            in_rd;
    logic                  in_reg_wen;
    logic [1:0]            in_wb_sel;
    logic [DATA_WIDTH-1:0] in_alu_result;
    logic [DATA_WIDTH-1:0] in_pc_plus4;
    logic [DATA_WIDTH-1:0] in_mem_rdata;
    logic [2:0]            in_funct3;

    logic [DATA_WIDTH-1:0] DataD;
    logic [4:0]            AddrD;
    logic                  RegWEn;
    logic                  wb_valid;
    logic                  load_misaligned;

    modport master (
        output in_valid, in_rd, in_reg_wen, in_wb_sel,
               in_alu_result, in_pc_plus4, in_mem_rdata, in_funct3,
        input  DataD, AddrD, RegWEn, wb_valid, load_misaligned
    );

    modport slave (
        input  in_valid, in_rd, in_reg_wen, in_wb_sel,
               in_alu_result, in_pc_plus4, in_mem_rdata, in_funct3,
        output DataD, AddrD, RegWEn, wb_valid, load_misaligned
    );
endinterface

// File: rtl/load_extend.sv
// Extracts the addressed byte/half/word from an aligned memory word and
// sign/zero-extends it; also reports alignment violations for the access size.
module load_extend
    import riscv_pkg::*;
(
    input  logic [XLEN-1:0] rdata,
    input  logic [1:0]      offset,
    input  logic [2:0]      funct3,
    output logic [XLEN-1:0] data,
    output logic            misaligned
);

    logic [7:0]  sel_byte;
    logic [15:0] sel_half;

    always_comb begin
        sel_byte = rdata[7:0];
        case (offset)
            2'd0:    sel_byte = rdata[7:0];
            2'd1:    sel_byte = rdata[15:8];
            2'd2:    sel_byte = rdata[23:16];
            default: sel_byte = rdata[31:24];
        endcase
        sel_half = offset[1] ? rdata[31:16] : rdata[15:0];
    end

    // Undefined load encodings return zero and are treated as misaligned.
    always_comb begin
        data       = '0;
        misaligned = 1'b0;
        case (funct3)
            F3_LB:   data = {{24{sel_byte[7]}}, sel_byte};
            F3_LBU:  data = {24'd0, sel_byte};
            F3_LH: begin
                data       = {{16{sel_half[15]}}, sel_half};
                misaligned = offset[0];
            end
            F3_LHU: begin
                data       = {16'd0, sel_half};
                misaligned = offset[0];
            end
            F3_LW: begin
                data       = rdata;
                misaligned = (offset != 2'd0);
            end
            default: begin
                data       = '0;
                misaligned = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/writeback_stage.sv
// MEM/WB pipeline register and write-back logic: drives the register-file
// write port from registered state and counts retired instructions.
module writeback_stage
    import riscv_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned CNT_WIDTH  = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 stall,
    input  logic                 flush,
    writeback_stage_if.slave     wb,
    output logic [CNT_WIDTH-1:0] instret
);

    memwb_t                q;
    memwb_t                d;
    logic [DATA_WIDTH-1:0] ext_data;
    logic                  ext_mis;
    logic [DATA_WIDTH-1:0] src_data;
    logic                  mis_c;
    logic                  wen_c;
    logic                  retire;

    always_comb begin
        d            = '0;
        d.valid      = wb.in_valid;
        d.rd         = wb.in_rd;
        d.reg_wen    = wb.in_reg_wen;
        d.wb_sel     = wb.in_wb_sel;
        d.alu_result = wb.in_alu_result;
        d.pc_plus4   = wb.in_pc_plus4;
        d.mem_rdata  = wb.in_mem_rdata;
        d.funct3     = wb.in_funct3;
    end

    // Flush inserts a fully zeroed bubble and overrides stall.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else if (flush) begin
            q <= '0;
        end else if (!stall) begin
            q <= d;
        end
    end

    load_extend u_load_extend (
        .rdata      (q.mem_rdata),
        .offset     (q.alu_result[1:0]),
        .funct3     (q.funct3),
        .data       (ext_data),
        .misaligned (ext_mis)
    );

    always_comb begin
        src_data = '0;
        case (q.wb_sel)
            WB_SEL_ALU: src_data = q.alu_result;
            WB_SEL_MEM: src_data = ext_data;
            WB_SEL_PC4: src_data = q.pc_plus4;
            default:    src_data = '0;
        endcase
    end

    assign mis_c = q.valid & (q.wb_sel == WB_SEL_MEM) & ext_mis;
    assign wen_c = q.valid & q.reg_wen & (q.rd != 5'd0) & ~mis_c
                 & (q.wb_sel != WB_SEL_RSVD);

    assign wb.DataD           = wen_c ? src_data : '0;
    assign wb.AddrD           = q.rd;
    assign wb.RegWEn          = wen_c;
    assign wb.wb_valid        = q.valid;
    assign wb.load_misaligned = mis_c;

    // Count only on the edge the instruction leaves, so a stall counts once.
    assign retire = q.valid & ~mis_c & (~stall | flush);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instret <= '0;
        end else if (retire) begin
            instret <= instret + CNT_WIDTH'(1);
        end
    end

endmodule

// File: tb/tb_writeback_stage.sv
// Directed bench for writeback_stage: a 32-bit counter build and a 4-bit
// counter build for rollover.
module tb_writeback_stage;
    import riscv_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        stall_a, flush_a, stall_b, flush_b;
    logic [31:0] instret_a;
    logic [3:0]  instret_b;

    int errors = 0;
    int checks = 0;

    logic [31:0] exp_ret;
    logic        held_ok;
    logic        pend_ok;
    logic [31:0] r0;

    logic [31:0] lb_exp  [4] = '{32'h0000_0001, 32'h0000_007F, 32'hFFFF_FFFF, 32'hFFFF_FF80};
    logic [31:0] lbu_exp [4] = '{32'h0000_0001, 32'h0000_007F, 32'h0000_00FF, 32'h0000_0080};

    writeback_stage_if #(.DATA_WIDTH(32)) ia ();
    writeback_stage_if #(.DATA_WIDTH(32)) ib ();

    writeback_stage #(.DATA_WIDTH(32), .CNT_WIDTH(32)) dut_a (
        .clk     (clk),
        .rst_n   (rst_n),
        .stall   (stall_a),
        .flush   (flush_a),
        .wb      (ia.slave),
        .instret (instret_a)
    );

    writeback_stage #(.DATA_WIDTH(32), .CNT_WIDTH(4)) dut_b (
        .clk     (clk),
        .rst_n   (rst_n),
        .stall   (stall_b),
        .flush   (flush_b),
        .wb      (ib.slave),
        .instret (instret_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic v, input logic [4:0] rd, input logic wen,
                         input logic [1:0] sel, input logic [31:0] alu,
                         input logic [31:0] pc4, input logic [31:0] rdata,
                         input logic [2:0] f3, input logic ok);
        ia.in_valid      = v;
        ia.in_rd         = rd;
        ia.in_reg_wen    = wen;
        ia.in_wb_sel     = sel;
        ia.in_alu_result = alu;
        ia.in_pc_plus4   = pc4;
        ia.in_mem_rdata  = rdata;
        ia.in_funct3     = f3;
        pend_ok          = ok;
    endtask

    // Advance one cycle, tracking when the held instruction of dut_a should retire.
    task automatic tick();
        if (held_ok && (!stall_a || flush_a)) exp_ret = exp_ret + 32'd1;
        if (flush_a)      held_ok = 1'b0;
        else if (!stall_a) held_ok = pend_ok;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        stall_a = 1'b0; flush_a = 1'b0; stall_b = 1'b0; flush_b = 1'b0;
        exp_ret = 32'd0; held_ok = 1'b0; pend_ok = 1'b0; r0 = 32'd0;
        issue(1'b1, 5'd7, 1'b1, WB_SEL_ALU, 32'hDEAD, 32'h0, 32'h0, 3'd0, 1'b0);
        ib.in_valid = 1'b0; ib.in_rd = 5'd1; ib.in_reg_wen = 1'b1; ib.in_wb_sel = WB_SEL_ALU;
        ib.in_alu_result = 32'h11; ib.in_pc_plus4 = 32'h0; ib.in_mem_rdata = 32'h0; ib.in_funct3 = 3'd0;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_datad",   ia.DataD, 32'h0);
        chk("rst_addrd",   32'(ia.AddrD), 32'h0);
        chk("rst_regwen",  32'(ia.RegWEn), 32'h0);
        chk("rst_valid",   32'(ia.wb_valid), 32'h0);
        chk("rst_instret", instret_a, 32'h0);
        chk("rst_instret_b", 32'(instret_b), 32'h0);
        rst_n = 1'b1;

        issue(1'b1, 5'd5, 1'b1, WB_SEL_ALU, 32'h1234, 32'h0, 32'h0, 3'd0, 1'b1);
        tick();
        chk("alu_datad",  ia.DataD, 32'h1234);
        chk("alu_regwen", 32'(ia.RegWEn), 32'h1);
        chk("alu_addrd",  32'(ia.AddrD), 32'd5);
        chk("alu_instret_before", instret_a, 32'd0);
        issue(1'b0, 5'd0, 1'b0, WB_SEL_ALU, 32'h0, 32'h0, 32'h0, 3'd0, 1'b0);
        tick();
        chk("alu_instret_after", instret_a, 32'd1);
        chk("bubble_regwen", 32'(ia.RegWEn), 32'h0);

        for (int i = 0; i < 4; i++) begin
            issue(1'b1, 5'd10, 1'b1, WB_SEL_MEM, 32'h100 + 32'(i), 32'h0, 32'h80FF7F01, F3_LB, 1'b1);
            tick();
            chk($sformatf("lb_off%0d", i), ia.DataD, lb_exp[i]);
        end
        for (int i = 0; i < 4; i++) begin
            issue(1'b1, 5'd11, 1'b1, WB_SEL_MEM, 32'h200 + 32'(i), 32'h0, 32'h80FF7F01, F3_LBU, 1'b1);
            tick();
            chk($sformatf("lbu_off%0d", i), ia.DataD, lbu_exp[i]);
        end
        issue(1'b1, 5'd12, 1'b1, WB_SEL_MEM, 32'h302, 32'h0, 32'h80FF7F01, F3_LH, 1'b1);
        tick();
        chk("lh_off2", ia.DataD, 32'hFFFF80FF);
        issue(1'b1, 5'd12, 1'b1, WB_SEL_MEM, 32'h300, 32'h0, 32'h80FF7F01, F3_LHU, 1'b1);
        tick();
        chk("lhu_off0", ia.DataD, 32'h00007F01);
        issue(1'b1, 5'd13, 1'b1, WB_SEL_MEM, 32'h400, 32'h0, 32'h80FF7F01, F3_LW, 1'b1);
        tick();
        chk("lw_off0", ia.DataD, 32'h80FF7F01);
        issue(1'b1, 5'd1, 1'b1, WB_SEL_PC4, 32'h0, 32'h2004, 32'h0, 3'd0, 1'b1);
        tick();
        chk("pc4_datad", ia.DataD, 32'h2004);
        issue(1'b1, 5'd2, 1'b1, WB_SEL_RSVD, 32'h55, 32'h0, 32'h0, 3'd0, 1'b1);
        tick();
        chk("rsvd_regwen", 32'(ia.RegWEn), 32'h0);
        chk("rsvd_datad",  ia.DataD, 32'h0);
        chk("loads_instret", instret_a, exp_ret);

        r0 = exp_ret + 32'd1;
        issue(1'b1, 5'd14, 1'b1, WB_SEL_MEM, 32'h502, 32'h0, 32'h80FF7F01, F3_LW, 1'b0);
        tick();
        chk("lw_mis_flag",   32'(ia.load_misaligned), 32'h1);
        chk("lw_mis_regwen", 32'(ia.RegWEn), 32'h0);
        chk("lw_mis_datad",  ia.DataD, 32'h0);
        issue(1'b1, 5'd14, 1'b1, WB_SEL_MEM, 32'h501, 32'h0, 32'h80FF7F01, F3_LH, 1'b0);
        tick();
        chk("lh_mis_flag",   32'(ia.load_misaligned), 32'h1);
        chk("lh_mis_regwen", 32'(ia.RegWEn), 32'h0);
        issue(1'b0, 5'd0, 1'b0, WB_SEL_ALU, 32'h0, 32'h0, 32'h0, 3'd0, 1'b0);
        tick();
        chk("mis_instret", instret_a, r0);
        chk("mis_cleared", 32'(ia.load_misaligned), 32'h0);

        issue(1'b1, 5'd9, 1'b1, WB_SEL_ALU, 32'h55, 32'h0, 32'h0, 3'd0, 1'b1);
        tick();
        r0 = instret_a;
        chk("stall_base", r0, exp_ret);
        stall_a = 1'b1;
        issue(1'b1, 5'd3, 1'b1, WB_SEL_ALU, 32'h33, 32'h0, 32'h0, 3'd0, 1'b1);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk($sformatf("stall%0d_regwen", i), 32'(ia.RegWEn), 32'h1);
            chk($sformatf("stall%0d_addrd", i), 32'(ia.AddrD), 32'd9);
            chk($sformatf("stall%0d_instret", i), instret_a, r0);
        end
        stall_a = 1'b0;
        tick();
        chk("unstall_instret", instret_a, r0 + 32'd1);
        chk("unstall_addrd", 32'(ia.AddrD), 32'd3);

        stall_a = 1'b1; flush_a = 1'b1;
        tick();
        chk("flush_valid",   32'(ia.wb_valid), 32'h0);
        chk("flush_regwen",  32'(ia.RegWEn), 32'h0);
        chk("flush_instret", instret_a, r0 + 32'd2);
        stall_a = 1'b0; flush_a = 1'b0;

        issue(1'b1, 5'd0, 1'b1, WB_SEL_ALU, 32'h99, 32'h0, 32'h0, 3'd0, 1'b1);
        tick();
        chk("x0_regwen", 32'(ia.RegWEn), 32'h0);
        chk("x0_datad",  ia.DataD, 32'h0);
        chk("x0_valid",  32'(ia.wb_valid), 32'h1);
        issue(1'b0, 5'd0, 1'b0, WB_SEL_ALU, 32'h0, 32'h0, 32'h0, 3'd0, 1'b0);
        tick();
        chk("x0_instret", instret_a, r0 + 32'd3);
        chk("model_instret", instret_a, exp_ret);

        issue(1'b1, 5'd6, 1'b1, WB_SEL_ALU, 32'h77, 32'h0, 32'h0, 3'd0, 1'b1);
        tick();
        stall_a = 1'b1;
        tick();
        chk("pre_rst_regwen", 32'(ia.RegWEn), 32'h1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_regwen",  32'(ia.RegWEn), 32'h0);
        chk("midrst_datad",   ia.DataD, 32'h0);
        chk("midrst_addrd",   32'(ia.AddrD), 32'h0);
        chk("midrst_valid",   32'(ia.wb_valid), 32'h0);
        chk("midrst_instret", instret_a, 32'h0);
        stall_a = 1'b0;
        issue(1'b0, 5'd0, 1'b0, WB_SEL_ALU, 32'h0, 32'h0, 32'h0, 3'd0, 1'b0);
        held_ok = 1'b0; exp_ret = 32'd0;
        @(negedge clk);
        rst_n = 1'b1;

        ib.in_valid = 1'b1;
        repeat (16) tick();
        chk("cnt4_at15", 32'(instret_b), 32'd15);
        tick();
        chk("cnt4_wrap0", 32'(instret_b), 32'd0);
        tick();
        chk("cnt4_wrap1", 32'(instret_b), 32'd1);
        chk("idle_instret_a", instret_a, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
